// File: rtl/lzw_string_unwind_if.sv
// Bundles the code input, dictionary read port and character output stream of the LZW string unwinder.
// The master modport is the surrounding decoder and dictionary; the slave modport is the unwinder.
`timescale 1ns/1ps
interface lzw_string_unwind_if #(
  parameter int CODE_W = 12
);
  logic              code_valid;
  logic              code_ready;
  logic [CODE_W-1:0] code_in;
  logic              dict_en;
  logic [CODE_W-1:0] dict_addr;
  logic [CODE_W-1:0] dict_prefix;
  logic [7:0]        dict_char;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_char;
  logic              out_last;
  logic [7:0]        first_char;
  logic              busy;
  logic              err;

  modport master (
    output code_valid, code_in, dict_prefix, dict_char, out_ready,
    input  code_ready, dict_en, dict_addr, out_valid, out_char, out_last,
           first_char, busy, err
  );

  modport slave (
    input  code_valid, code_in, dict_prefix, dict_char, out_ready,
    output code_ready, dict_en, dict_addr, out_valid, out_char, out_last,
           first_char, busy, err
  );
endinterface

// File: rtl/lzw_string_unwind.sv
// Expands one LZW code by walking its prefix chain into a LIFO stack, then streams
// the characters out first-to-last and exposes the string's first character.
`timescale 1ns/1ps
module lzw_string_unwind #(
  parameter int CODE_W      = 12,
  parameter int STACK_DEPTH = 4096,
  parameter int STACK_AW    = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  lzw_string_unwind_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_WALK, S_EMIT} state_t;

  localparam logic [STACK_AW:0] DEPTH_C = (STACK_AW+1)'(STACK_DEPTH);
  localparam logic [STACK_AW:0] SP_ONE  = {{STACK_AW{1'b0}}, 1'b1};

  state_t              r_state, w_state_next;
  logic [STACK_AW:0]   r_sp, w_sp_next, w_sp_inc, w_sp_inc2, w_sp_dec;
  logic [7:0]          r_stack [STACK_DEPTH];
  logic [CODE_W-1:0]   r_dict_addr;
  logic [7:0]          r_first_char;
  logic                r_err;

  logic                w_wr0_en, w_wr1_en;
  logic [STACK_AW-1:0] w_wr0_idx, w_wr1_idx;
  logic [7:0]          w_wr0_data, w_wr1_data;
  logic                w_fc_load;
  logic [7:0]          w_fc_data;
  logic                w_err_set;
  logic                w_dict_en;
  logic [CODE_W-1:0]   w_dict_addr;
  logic                w_code_lit, w_prefix_lit;

  assign w_sp_inc     = r_sp + SP_ONE;
  assign w_sp_inc2    = w_sp_inc + SP_ONE;
  assign w_sp_dec     = r_sp - SP_ONE;
  assign w_code_lit   = (bus.code_in[CODE_W-1:8] == '0);
  assign w_prefix_lit = (bus.dict_prefix[CODE_W-1:8] == '0);

  always_comb begin
    w_state_next   = r_state;
    w_sp_next      = r_sp;
    w_wr0_en       = 1'b0;
    w_wr0_idx      = r_sp[STACK_AW-1:0];
    w_wr0_data     = '0;
    w_wr1_en       = 1'b0;
    w_wr1_idx      = w_sp_inc[STACK_AW-1:0];
    w_wr1_data     = '0;
    w_fc_load      = 1'b0;
    w_fc_data      = '0;
    w_err_set      = 1'b0;
    w_dict_en      = 1'b0;
    w_dict_addr    = r_dict_addr;
    bus.code_ready = 1'b0;
    bus.busy       = 1'b1;
    bus.out_valid  = 1'b0;
    bus.out_last   = 1'b0;
    bus.out_char   = '0;
    case (r_state)
      S_IDLE: begin
        bus.code_ready = 1'b1;
        bus.busy       = 1'b0;
        if (bus.code_valid) begin
          if (w_code_lit) begin
            w_wr0_en     = 1'b1;
            w_wr0_data   = bus.code_in[7:0];
            w_sp_next    = w_sp_inc;
            w_fc_load    = 1'b1;
            w_fc_data    = bus.code_in[7:0];
            w_state_next = S_EMIT;
          end else begin
            w_dict_en    = 1'b1;
            w_dict_addr  = bus.code_in;
            w_state_next = S_WALK;
          end
        end
      end
      S_WALK: begin
        // Overflow covers both the append push and the trailing literal push.
        if (r_sp == DEPTH_C || (w_prefix_lit && w_sp_inc == DEPTH_C)) begin
          w_err_set    = 1'b1;
          w_sp_next    = '0;
          w_state_next = S_IDLE;
        end else if (w_prefix_lit) begin
          w_wr0_en     = 1'b1;
          w_wr0_data   = bus.dict_char;
          w_wr1_en     = 1'b1;
          w_wr1_data   = bus.dict_prefix[7:0];
          w_sp_next    = w_sp_inc2;
          w_fc_load    = 1'b1;
          w_fc_data    = bus.dict_prefix[7:0];
          w_state_next = S_EMIT;
        end else begin
          w_wr0_en    = 1'b1;
          w_wr0_data  = bus.dict_char;
          w_sp_next   = w_sp_inc;
          w_dict_en   = 1'b1;
          w_dict_addr = bus.dict_prefix;
        end
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_char  = r_stack[w_sp_dec[STACK_AW-1:0]];
        bus.out_last  = (r_sp == SP_ONE);
        if (bus.out_ready) begin
          w_sp_next = w_sp_dec;
          if (r_sp == SP_ONE) w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sp         <= '0;
      r_dict_addr  <= '0;
      r_first_char <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sp    <= w_sp_next;
      if (w_dict_en) r_dict_addr  <= w_dict_addr;
      if (w_fc_load) r_first_char <= w_fc_data;
      if (w_err_set) r_err        <= 1'b1;
    end
  end

  // Stack contents need no reset: sp alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_wr0_en) r_stack[w_wr0_idx] <= w_wr0_data;
    if (w_wr1_en) r_stack[w_wr1_idx] <= w_wr1_data;
  end

  assign bus.dict_en    = w_dict_en;
  assign bus.dict_addr  = w_dict_addr;
  assign bus.first_char = r_first_char;
  assign bus.err        = r_err;
endmodule

// File: doc/lzw_string_unwind.md
Name: lzw_string_unwind

Overview:
- Decoder-side counterpart of the LZW compressor's dictionary write path.
- Takes one 12-bit LZW code, walks the prefix chain through the dictionary read port (prefix-code RAM plus append-character RAM) and pushes characters onto a LIFO stack.
- Then emits the decoded string in forward order on a valid/ready byte stream.
- Also presents the string's first character, which the decoder control needs for new-entry creation and the KwKwK case.

Parameters:
- CODE_W, 12, code/address width; codes 0..255 are literals, 256..2^CODE_W-1 are dictionary entries.
- STACK_DEPTH, 4096, maximum string length held (characters).
- STACK_AW, 12, stack pointer width; STACK_AW must satisfy 2^STACK_AW >= STACK_DEPTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- code_valid  in  1  input code valid
- code_ready  out  1  block can accept a code; high only in IDLE
- code_in  in  CODE_W  code to expand
- dict_en  out  1  dictionary read enable
- dict_addr  out  CODE_W  dictionary read address
- dict_prefix  in  CODE_W  prefix code; registered RAM output, valid the cycle after dict_en
- dict_char  in  8  append character; same timing as dict_prefix
- out_valid  out  1  output character valid
- out_ready  in  1  downstream accepts character
- out_char  out  8  decoded character, first-to-last order
- out_last  out  1  marks last character of string
- first_char  out  8  first character of most recently decoded string
- busy  out  1  high in any state except IDLE
- err  out  1  sticky stack overflow flag; cleared only by reset

Behaviour:
- Reset: all outputs are cleared.
  - State is IDLE and sp=0.
  - code_ready=1; out_valid, out_last, dict_en, busy, err = 0.
  - dict_addr, out_char, first_char = 0.
- States: IDLE, WALK, EMIT.
- IDLE, when code_valid & code_ready:
  - Literal (code_in < 256): push code_in[7:0], go to EMIT.
  - Otherwise: drive dict_en=1 and dict_addr=code_in in the same cycle, go to WALK.
- WALK (dict data valid every cycle in this state):
  - Push dict_char.
  - If dict_prefix < 256: also push dict_prefix[7:0] in the same cycle (two pushes), go to EMIT.
  - Else: drive dict_en=1 and dict_addr=dict_prefix combinationally, stay in WALK.
  - Throughput is one dictionary read per cycle.
- dict_en is 0 in all other states and cycles; dict_addr holds its last value when dict_en=0.
- EMIT:
  - out_valid=1 and out_char = stack top.
  - out_last=1 when sp==1.
  - A pop occurs on out_valid & out_ready.
  - After the pop with out_last=1, go to IDLE; code_ready is high in the following cycle.
  - out_char and out_last are held stable while out_valid & !out_ready.
- first_char: registered with the last character pushed (the string's first character) on entry to EMIT; held until the next EMIT entry.
- Latency for string length L: code accepted in cycle T gives the first out_valid in cycle T+L. Examples: literal at T+1; a two-character string at T+2.
- No new code is accepted until the full string has been emitted; no overlap between strings.
- Overflow: a push that would make sp exceed STACK_DEPTH is an overflow, including the second push of a double push.
  - Set err=1, discard the stack (sp=0), drive no output, return to IDLE.
  - Further codes are processed normally; err stays 1.
- Self-referential or cyclic dictionary content terminates only via overflow. This is the required behaviour.
- Out-of-range code values are not checked; the decoder control guarantees code < next free code.
- Reset asserted mid-WALK or mid-EMIT: immediate return to reset values; the partial string is lost with no further output.
- Stack storage is an implementation choice (inferred RAM or registers). The cycle timing above must hold, including out_valid back-to-back at one character per cycle when out_ready=1.

Test Plan:
- Dictionary model used by all scenarios: 256=(0x41,0x42), 257=(256,0x43), 258=(257,0x44), 1-cycle read latency.
- Reset: release rst_n with no stimulus -> code_ready=1, all other outputs 0 for 10 cycles.
- Literal: code_in=0x041 accepted at T -> out_valid at T+1 with out_char=0x41, out_last=1; first_char=0x41; no dict_en pulse; code_ready=1 at T+2.
- Chain: code 258 at T -> dict_addr 258, 257, 256 at T, T+1, T+2; out_char 0x41, 0x42, 0x43, 0x44 at T+4..T+7 with out_ready=1; out_last only on 0x44; first_char=0x41.
- Backpressure: code 258 with out_ready pattern 1,0,1,0,... -> same 4 characters, each held while stalled, none dropped or duplicated; code_ready low until the cycle after the 0x44 handshake.
- Overflow: STACK_DEPTH=4, chain of 5 entries (260->259->258->257->256) -> err=1, out_valid never asserted, back in IDLE; a following literal 0x20 is decoded correctly with err still 1.
- Reset mid-operation: rst_n pulsed low during WALK of code 258 -> all outputs at reset values immediately, no out_valid afterward; next code 257 decodes to 0x41, 0x42, 0x43.
